// File: rtl/fetch_if.sv
// Fetch-stage control/data bundle: decode-side controls and program-load port in,
// fetch address and IF/ID register contents out.
interface fetch_if #(
  parameter int ADDR_W = 8
);
  logic              pc_enable;
  logic              if_id_enable;
  logic              mux_sel_IF;
  logic [31:0]       pc_branch_value;
  logic              IF_flush;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [31:0]       pc_current;
  logic [31:0]       instruction_out;
  logic [31:0]       pc_out;
  logic              valid_out;
  logic [31:0]       fetch_count;

  modport master (
    output pc_enable, if_id_enable, mux_sel_IF, pc_branch_value, IF_flush,
           imem_we, imem_waddr, imem_wdata,
    input  pc_current, instruction_out, pc_out, valid_out, fetch_count
  );

  modport slave (
    input  pc_enable, if_id_enable, mux_sel_IF, pc_branch_value, IF_flush,
           imem_we, imem_waddr, imem_wdata,
    output pc_current, instruction_out, pc_out, valid_out, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC register, word-addressed instruction memory with a load port,
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic   clock,
  input  logic   reset,
  fetch_if.slave bus
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] imem_q [IMEM_DEPTH];
  logic [31:0] rd_data_s;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  // Upper PC bits are dropped so fetches wrap modulo the memory depth.
  assign rd_data_s = imem_q[pc_q[AW+1:2]];

  // Program-load write port; memory contents survive reset.
  always_ff @(posedge clock) begin
    if (bus.imem_we) begin
      imem_q[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  // Next PC: a redirect requested during a stall is dropped, decode re-asserts it.
  always_comb begin
    pc_d = pc_q;
    if (!bus.pc_enable) begin
      pc_d = pc_q;
    end else if (bus.mux_sel_IF) begin
      pc_d = bus.pc_branch_value;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // IF/ID next state: flush beats a held register.
  always_comb begin
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    count_d  = count_q;
    if (bus.IF_flush) begin
      instr_d  = NOP_INSTR;
      pc_out_d = pc_q;
      valid_d  = 1'b0;
    end else if (bus.if_id_enable) begin
      instr_d  = rd_data_s;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      count_d  = count_q + 32'd1;
    end else begin
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= 32'h0000_0000;
      valid_q  <= 1'b0;
      count_q  <= 32'h0000_0000;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign bus.pc_current      = pc_q;
  assign bus.instruction_out = instr_q;
  assign bus.pc_out          = pc_out_q;
  assign bus.valid_out       = valid_q;
  assign bus.fetch_count     = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: preload, sequential fetch, async reset, stall,
// taken branch, flush priority, same-cycle write/read and PC wrap.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] M0  = 32'h0050_0093;
  localparam logic [31:0] M1  = 32'h0010_0113;
  localparam logic [31:0] M2  = 32'h0020_81B3;
  localparam logic [31:0] M3  = 32'h0000_0013;
  localparam logic [31:0] M16 = 32'h00A0_0213;
  localparam logic [31:0] M17 = 32'h0000_0293;
  localparam logic [31:0] M18 = 32'h0000_0513;
  localparam logic [31:0] M255 = 32'hDEAD_BEEF;
  localparam logic [31:0] MNEW = 32'h1111_1111;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_mis;

  fetch_if #(.ADDR_W(8)) fif ();

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .IMEM_DEPTH(256),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(fif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] pco, input logic vld, input logic [31:0] cnt);
    check_eq({tag, ".pc"},    fif.pc_current, pc);
    check_eq({tag, ".instr"}, fif.instruction_out, ins);
    check_eq({tag, ".pcout"}, fif.pc_out, pco);
    check_eq({tag, ".valid"}, {31'd0, fif.valid_out}, {31'd0, vld});
    check_eq({tag, ".count"}, fif.fetch_count, cnt);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    fif.imem_we    = 1'b1;
    fif.imem_waddr = a;
    fif.imem_wdata = d;
    tick();
    fif.imem_we    = 1'b0;
  endtask

  task automatic set_ctl(input logic pe, input logic ie, input logic ms,
                         input logic fl, input logic [31:0] br);
    fif.pc_enable       = pe;
    fif.if_id_enable    = ie;
    fif.mux_sel_IF      = ms;
    fif.IF_flush        = fl;
    fif.pc_branch_value = br;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b1;
    fif.imem_we = 1'b0;
    fif.imem_waddr = 8'd0;
    fif.imem_wdata = 32'd0;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);

    // Preload under reset
    load_word(8'd0, M0);
    load_word(8'd1, M1);
    load_word(8'd2, M2);
    load_word(8'd3, M3);
    load_word(8'd16, M16);
    load_word(8'd17, M17);
    load_word(8'd18, M18);
    load_word(8'd255, M255);
    check_all("rst", 32'h0, NOP, 32'h0, 1'b0, 32'd0);

    // Sequential fetch
    reset = 1'b0;
    tick(); check_all("seq1", 32'h4, M0, 32'h0, 1'b1, 32'd1);
    tick(); check_all("seq2", 32'h8, M1, 32'h4, 1'b1, 32'd2);

    // Async reset mid-cycle at PC=8
    reset = 1'b1;
    #1;
    check_all("arst", 32'h0, NOP, 32'h0, 1'b0, 32'd0);
    reset = 1'b0;

    // Stall at PC=4
    tick(); check_all("pre_stall", 32'h4, M0, 32'h0, 1'b1, 32'd1);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); check_all("stall1", 32'h4, M0, 32'h0, 1'b1, 32'd1);
    tick(); check_all("stall2", 32'h4, M0, 32'h0, 1'b1, 32'd1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(); check_all("resume", 32'h8, M1, 32'h4, 1'b1, 32'd2);

    // Taken branch with flush at PC=8
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    tick(); check_all("br_bubble", 32'h40, NOP, 32'h8, 1'b0, 32'd2);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(); check_all("br_target", 32'h44, M16, 32'h40, 1'b1, 32'd3);

    // Flush overrides hold
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    tick(); check_all("flush_hold", 32'h48, NOP, 32'h44, 1'b0, 32'd3);
    // Redirect ignored while PC stalled
    set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
    tick(); check_all("redir_stall", 32'h48, M18, 32'h48, 1'b1, 32'd4);

    // Wrap within memory depth
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 32'h3FC);
    tick(); check_all("to_top", 32'h3FC, M18, 32'h48, 1'b1, 32'd5);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(); check_all("top_word", 32'h400, M255, 32'h3FC, 1'b1, 32'd6);
    tick(); check_all("mem_wrap", 32'h404, M0, 32'h400, 1'b1, 32'd7);

    // 32-bit PC wrap
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
    tick(); check_all("to_max", 32'hFFFF_FFFC, M1, 32'h404, 1'b1, 32'd8);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(); check_all("pc_wrap", 32'h0, M255, 32'hFFFF_FFFC, 1'b1, 32'd9);

    // Same-cycle write and read of word 0 returns old data
    fif.imem_we = 1'b1;
    fif.imem_waddr = 8'd0;
    fif.imem_wdata = MNEW;
    tick(); check_all("wr_old", 32'h4, M0, 32'h0, 1'b1, 32'd10);
    fif.imem_we = 1'b0;
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(); check_all("back0", 32'h0, M1, 32'h4, 1'b1, 32'd11);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(); check_all("wr_new", 32'h4, MNEW, 32'h0, 1'b1, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
